// File: rtl/io_bus_ctrl.sv
// Bus bridge from a single request/acknowledge master to four peripheral slots.
// It also holds an internal interrupt and status register block at 0xF000.
module io_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        io_bus_enable,
  input  logic [15:0] io_address,
  input  logic        io_rw,
  input  logic [1:0]  io_byte_enable,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        io_acknowledge,
  output logic        io_irq,
  output logic [3:0]  per_sel,
  output logic [11:0] per_addr,
  output logic        per_rw,
  output logic [1:0]  per_be,
  output logic [15:0] per_wdata,
  input  logic [63:0] per_rdata,
  input  logic [3:0]  per_ready,
  input  logic [3:0]  per_irq
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, GAP} state_t;

  localparam logic [15:0] DEAD_DATA    = 16'hDEAD;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [3:0]  region_reg;
  logic [7:0]  count_reg;
  logic [3:0]  pend_reg;
  logic [3:0]  mask_reg;
  logic [3:0]  irq_prev_reg;
  logic [1:0]  status_reg;

  logic [15:0] slot_rdata [4];
  logic [3:0]  req_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_rdata[gi] = per_rdata[16*gi +: 16];
      assign req_sel[gi]    = (io_address[15:12] == 4'(gi));
    end
  endgenerate

  logic        is_slot;
  logic        is_int;
  logic        in_access;
  logic        slot_ready;
  logic        timeout_hit;
  logic [1:0]  slot_idx;
  logic [3:0]  offset;
  logic [15:0] int_rdata;
  logic        int_we;
  logic [3:0]  pend_clr;
  logic [3:0]  irq_rise;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;

  // per_addr doubles as the latched address, so its low nibble is the register offset.
  always_comb begin
    slot_idx    = region_reg[1:0];
    is_slot     = (region_reg[3:2] == 2'b00);
    is_int      = (region_reg == 4'hF);
    in_access   = (state_reg == ACCESS);
    slot_ready  = per_ready[slot_idx];
    timeout_hit = (count_reg == TIMEOUT_LAST);
    offset      = per_addr[3:0];
    int_rdata   = 16'h0000;
    case (offset)
      4'h0:    int_rdata = {12'h000, pend_reg};
      4'h2:    int_rdata = {12'h000, mask_reg};
      4'h4:    int_rdata = {14'h0000, status_reg};
      default: int_rdata = 16'h0000;
    endcase
    int_we     = in_access && is_int && !per_rw && per_be[0];
    pend_clr   = 4'h0;
    status_clr = 2'b00;
    if (int_we && offset == 4'h0) pend_clr = per_wdata[3:0];
    if (int_we && offset == 4'h4) status_clr = per_wdata[1:0];
    status_set[0] = in_access && is_slot && !slot_ready && timeout_hit;
    status_set[1] = in_access && !is_slot && !is_int;
    irq_rise      = per_irq & ~irq_prev_reg;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg      <= IDLE;
      region_reg     <= 4'h0;
      count_reg      <= 8'h00;
      per_sel        <= 4'h0;
      per_addr       <= 12'h000;
      per_rw         <= 1'b0;
      per_be         <= 2'b00;
      per_wdata      <= 16'h0000;
      io_acknowledge <= 1'b0;
      io_read_data   <= 16'h0000;
    end else begin
      io_acknowledge <= 1'b0;
      io_read_data   <= 16'h0000;
      case (state_reg)
        IDLE: begin
          if (io_bus_enable) begin
            state_reg  <= ACCESS;
            region_reg <= io_address[15:12];
            per_addr   <= io_address[11:0];
            per_rw     <= io_rw;
            per_be     <= io_byte_enable;
            per_wdata  <= io_write_data;
            per_sel    <= req_sel;
            count_reg  <= 8'h00;
          end
        end
        ACCESS: begin
          if (is_slot) begin
            // Ready is tested first so a late ready on the last allowed cycle still completes.
            if (slot_ready) begin
              state_reg      <= ACK;
              per_sel        <= 4'h0;
              io_acknowledge <= 1'b1;
              io_read_data   <= per_rw ? slot_rdata[slot_idx] : 16'h0000;
            end else if (timeout_hit) begin
              state_reg      <= ACK;
              per_sel        <= 4'h0;
              io_acknowledge <= 1'b1;
              io_read_data   <= per_rw ? DEAD_DATA : 16'h0000;
            end else begin
              count_reg <= count_reg + 8'h01;
            end
          end else begin
            state_reg      <= ACK;
            per_sel        <= 4'h0;
            io_acknowledge <= 1'b1;
            io_read_data   <= per_rw ? (is_int ? int_rdata : DEAD_DATA) : 16'h0000;
          end
        end
        ACK:     state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sets are OR-ed in after the clears so a coincident event is never lost.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq_prev_reg <= 4'h0;
      pend_reg     <= 4'h0;
      mask_reg     <= 4'h0;
      status_reg   <= 2'b00;
      io_irq       <= 1'b0;
    end else begin
      irq_prev_reg <= per_irq;
      pend_reg     <= (pend_reg & ~pend_clr) | irq_rise;
      status_reg   <= (status_reg & ~status_clr) | status_set;
      if (int_we && offset == 4'h2) mask_reg <= per_wdata[3:0];
      io_irq <= |(pend_reg & mask_reg);
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomised bench for io_bus_ctrl: a transaction-level model predicts every
// output cycle by cycle, and directed scenarios pin the model with literals.
module tb_io_bus_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] io_address;
  logic        rw;
  logic [1:0]  be;
  logic [15:0] wd;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;
  logic [3:0]  per_sel;
  logic [11:0] per_addr;
  logic        per_rw;
  logic [1:0]  per_be;
  logic [15:0] per_wdata;
  logic [63:0] per_rdata;
  logic [3:0]  per_ready;
  logic [3:0]  per_irq;

  always #5 clk = ~clk;

  io_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .io_bus_enable  (en),
    .io_address     (io_address),
    .io_rw          (rw),
    .io_byte_enable (be),
    .io_write_data  (wd),
    .io_read_data   (io_read_data),
    .io_acknowledge (io_acknowledge),
    .io_irq         (io_irq),
    .per_sel        (per_sel),
    .per_addr       (per_addr),
    .per_rw         (per_rw),
    .per_be         (per_be),
    .per_wdata      (per_wdata),
    .per_rdata      (per_rdata),
    .per_ready      (per_ready),
    .per_irq        (per_irq)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle
  bit          exp_valid = 0;
  bit          per_chk = 0;
  logic [3:0]  exp_sel;
  logic        exp_ack;
  logic [15:0] exp_rd;
  logic        exp_irq;
  logic [11:0] exp_paddr;
  logic        exp_prw;
  logic [1:0]  exp_pbe;
  logic [15:0] exp_pwd;

  // Register model and the updates due at the next clock edge
  logic [3:0] m_pend, m_mask, m_prev;
  logic [1:0] m_status;
  logic       m_irq;
  logic [3:0] ev_pend_clr;
  bit         ev_mask_we;
  logic [3:0] ev_mask_val;
  logic [1:0] ev_status_clr, ev_status_set;
  bit         irq_random = 0;

  int sel_run = 0;
  int last_sel = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("per_sel", 32'(per_sel), 32'(exp_sel));
      check("io_acknowledge", 32'(io_acknowledge), 32'(exp_ack));
      check("io_read_data", 32'(io_read_data), 32'(exp_rd));
      check("io_irq", 32'(io_irq), 32'(exp_irq));
      if (per_chk) begin
        check("per_addr", 32'(per_addr), 32'(exp_paddr));
        check("per_rw", 32'(per_rw), 32'(exp_prw));
        check("per_be", 32'(per_be), 32'(exp_pbe));
        check("per_wdata", 32'(per_wdata), 32'(exp_pwd));
      end
    end
    if (rst) sel_run = 0;
    else begin
      if (per_sel != 4'h0) sel_run++;
      if (io_acknowledge) begin
        last_sel = sel_run;
        sel_run  = 0;
      end
    end
  end

  task automatic clear_events();
    ev_pend_clr   = 4'h0;
    ev_mask_we    = 0;
    ev_mask_val   = 4'h0;
    ev_status_clr = 2'b00;
    ev_status_set = 2'b00;
  endtask

  // Advance one clock: apply the model's edge update, then new random background inputs.
  task automatic cyc();
    logic [3:0] rise;
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_status = 0; m_irq = 0;
    end else begin
      rise     = per_irq & ~m_prev;
      m_irq    = |(m_pend & m_mask);
      m_pend   = (m_pend & ~ev_pend_clr) | rise;
      m_prev   = per_irq;
      if (ev_mask_we) m_mask = ev_mask_val;
      m_status = (m_status & ~ev_status_clr) | ev_status_set;
    end
    clear_events();
    #1;
    if (irq_random)
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) per_irq[i] = ~per_irq[i];
    per_rdata = {$urandom, $urandom};
    per_ready = 4'($urandom);
    exp_irq   = m_irq;
  endtask

  task automatic idle(input int k);
    en = 0; exp_sel = 0; exp_ack = 0; exp_rd = 0; per_chk = 0;
    repeat (k) cyc();
  endtask

  task automatic do_reset();
    rst = 1; en = 0;
    m_pend = 0; m_mask = 0; m_prev = 0; m_status = 0; m_irq = 0;
    clear_events();
    exp_sel = 0; exp_ack = 0; exp_rd = 0; exp_irq = 0;
    per_chk = 1; exp_paddr = 0; exp_prw = 0; exp_pbe = 0; exp_pwd = 0;
    #1;
    check("reset per_sel", 32'(per_sel), 32'h0);
    check("reset ack", 32'(io_acknowledge), 32'h0);
    check("reset read_data", 32'(io_read_data), 32'h0);
    check("reset irq", 32'(io_irq), 32'h0);
    check("reset per_addr", 32'(per_addr), 32'h0);
    check("reset per_wdata", 32'(per_wdata), 32'h0);
    exp_valid = 1;
    repeat (2) cyc();
    rst = 0; per_chk = 0;
  endtask

  // One complete transfer. d = cycles the selected slot holds ready low.
  task automatic xfer(input logic [15:0] a, input logic r, input logic [1:0] b,
                      input logic [15:0] w, input int d, input logic [15:0] sdata,
                      input logic [3:0] irq_a1, output logic [15:0] got);
    logic [3:0]  hi;
    logic [1:0]  s;
    bit          slot, intl, tmo;
    int          n;
    logic [15:0] data;
    hi   = a[15:12];
    s    = hi[1:0];
    slot = (hi < 4);
    intl = (hi == 4'hF);
    tmo  = slot && (d >= TO);
    n    = slot ? ((d < TO) ? d + 1 : TO) : 1;
    data = 16'h0000;
    en = 1; io_address = a; rw = r; be = b; wd = w;
    exp_sel = 0; exp_ack = 0; exp_rd = 0; per_chk = 0;
    cyc();
    for (int i = 1; i <= n; i++) begin
      exp_sel = slot ? (4'b0001 << s) : 4'h0;
      per_chk = 1; exp_paddr = a[11:0]; exp_prw = r; exp_pbe = b; exp_pwd = w;
      if (slot) begin
        per_ready[s] = (i > d);
        per_rdata[int'(s)*16 +: 16] = sdata;
      end
      if (i == 1) begin
        per_irq = per_irq | irq_a1;
        if (intl) begin
          case (a[3:0])
            4'h0:    data = {12'h000, m_pend};
            4'h2:    data = {12'h000, m_mask};
            4'h4:    data = {14'h0000, m_status};
            default: data = 16'h0000;
          endcase
          if (!r && b[0]) begin
            if (a[3:0] == 4'h0) ev_pend_clr = w[3:0];
            if (a[3:0] == 4'h2) begin ev_mask_we = 1; ev_mask_val = w[3:0]; end
            if (a[3:0] == 4'h4) ev_status_clr = w[1:0];
          end
        end else if (!slot) begin
          data = 16'hDEAD;
          ev_status_set[1] = 1'b1;
        end
      end
      if (i == n && slot) begin
        if (tmo) begin
          data = 16'hDEAD;
          ev_status_set[0] = 1'b1;
        end else data = sdata;
      end
      cyc();
    end
    exp_sel = 0; per_chk = 0; exp_ack = 1; exp_rd = r ? data : 16'h0000;
    en = 1'($urandom);
    @(negedge clk); #1;
    got = io_read_data;
    cyc();
    exp_ack = 0; exp_rd = 0;
    en = 1'($urandom);
    cyc();
    en = 0;
    $display("xfer addr=%h rw=%0d be=%b wdata=%h ready_delay=%0d rdata=%h", a, r, b, w, d, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [3:0]  hi;
    logic [15:0] a;
    rst = 1; en = 0; io_address = 0; rw = 0; be = 0; wd = 0;
    per_rdata = 0; per_ready = 0; per_irq = 0;
    @(posedge clk); #1;
    do_reset();
    idle(2);

    // Slot 2 read, ready already high
    xfer(16'h2000, 1, 2'b11, 16'h0000, 0, 16'h1234, 4'h0, got);
    check("slot2 read data", 32'(got), 32'h1234);
    check("slot2 sel cycles", 32'(last_sel), 32'd1);

    // Slot 1 write with ready low for 4 cycles
    xfer(16'h1010, 0, 2'b11, 16'h00AB, 4, 16'h0000, 4'h0, got);
    check("slot1 write data", 32'(got), 32'h0000);
    check("slot1 sel cycles", 32'(last_sel), 32'd5);

    // Timeout on slot 0, then STATUS read and clear
    xfer(16'h0000, 1, 2'b11, 16'h0000, 100, 16'h0000, 4'h0, got);
    check("timeout data", 32'(got), 32'hDEAD);
    check("timeout sel cycles", 32'(last_sel), 32'd8);
    xfer(16'hF004, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("status after timeout", 32'(got), 32'h0001);
    xfer(16'hF004, 0, 2'b01, 16'h0001, 0, 16'h0000, 4'h0, got);
    xfer(16'hF004, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("status cleared", 32'(got), 32'h0000);

    // Unmapped read, then interrupt path
    xfer(16'h5000, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("unmapped data", 32'(got), 32'hDEAD);
    xfer(16'hF004, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("status decode err", 32'(got), 32'h0002);
    xfer(16'hF002, 0, 2'b01, 16'h0003, 0, 16'h0000, 4'h0, got);
    per_irq = 4'b0010; idle(1);
    per_irq = 4'b0000; idle(3);
    xfer(16'hF000, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("pend after pulse", 32'(got), 32'h0002);
    check("irq asserted", 32'(io_irq), 32'h1);
    xfer(16'hF000, 0, 2'b01, 16'h0002, 0, 16'h0000, 4'h0, got);
    idle(2);
    check("irq cleared", 32'(io_irq), 32'h0);

    // Set beats write-1-clear on pend[0]
    per_irq = 4'b0001; idle(1);
    per_irq = 4'b0000; idle(2);
    xfer(16'hF000, 0, 2'b01, 16'h0001, 0, 16'h0000, 4'b0001, got);
    per_irq = 4'b0000; idle(1);
    xfer(16'hF000, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("pend set wins", 32'(got), 32'h0001);
    xfer(16'hF000, 0, 2'b01, 16'h0001, 0, 16'h0000, 4'h0, got);
    xfer(16'hF000, 1, 2'b11, 16'h0000, 0, 16'h0000, 4'h0, got);
    check("pend cleared", 32'(got), 32'h0000);

    // Reset in the middle of a slot access
    en = 1; io_address = 16'h1000; rw = 1; be = 2'b11; wd = 16'h0000;
    exp_sel = 0; exp_ack = 0; exp_rd = 0; per_chk = 0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      exp_sel = 4'b0010; per_ready[1] = 1'b0;
      cyc();
    end
    per_ready[1] = 1'b0;
    do_reset();
    idle(2);
    xfer(16'h1000, 1, 2'b11, 16'h0000, 1, 16'h5A5A, 4'h0, got);
    check("after reset data", 32'(got), 32'h5A5A);

    // Randomised traffic with background interrupts
    irq_random = 1;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: hi = 4'($urandom_range(0, 3));
        4:          hi = 4'hF;
        default:    hi = 4'($urandom_range(4, 14));
      endcase
      a = {hi, 12'($urandom)};
      if (hi == 4'hF && $urandom_range(0, 3) != 0)
        a[3:0] = 4'($urandom_range(0, 2) * 2);
      xfer(a, 1'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, 12),
           16'($urandom), 4'h0, got);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the number of ACCESS cycles allowed before an abort (legal range 1..255).
REQ-002 The block SHALL have port clk_clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port reset_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 io_bus_enable, input, 1 bit: transfer request, held high by the bus master until the acknowledge.
REQ-005 io_address, input, 16 bits; io_rw, input, 1 bit (1=read, 0=write); io_byte_enable, input, 2 bits; io_write_data, input, 16 bits.
REQ-006 io_read_data, output, 16 bits; io_acknowledge, output, 1 bit; io_irq, output, 1 bit.
REQ-007 per_sel, output, 4 bits: one-hot peripheral slot select.
REQ-008 per_addr, output, 12 bits; per_rw, output, 1 bit; per_be, output, 2 bits; per_wdata, output, 16 bits.
REQ-009 per_rdata, input, 64 bits: slot i read data on bits [16i+15:16i].
REQ-010 per_ready, input, 4 bits: per-slot access completion.
REQ-011 per_irq, input, 4 bits: per-slot level interrupt.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS, ACK and GAP.
REQ-013 IDLE with io_bus_enable=1: latch address, rw, byte_enable and write_data, clear the timeout counter, go to ACCESS.
REQ-014 Address decode SHALL use io_address[15:12]:
- 0..3 select slot 0..3.
- 0xF selects the internal registers.
- All other values are unmapped.
REQ-015 ACCESS (slot): drive per_sel one-hot and per_addr = latched address[11:0]; hold per_rw, per_be and per_wdata stable from the latched values.
REQ-016 ACCESS (slot): when per_ready[slot]=1, capture that slot's per_rdata and go to ACK.
REQ-017 ACCESS timeout: when the counter reaches TIMEOUT-1 with ready still low, return data 0xDEAD, set STATUS.bit0 and go to ACK.
REQ-018 If ready and timeout occur in the same cycle, ready SHALL win.
REQ-019 ACCESS (internal or unmapped) SHALL complete in one cycle with no ready wait.
REQ-020 An unmapped access SHALL read 0xDEAD, ignore the write, and set STATUS.bit1.
REQ-021 ACK: io_acknowledge=1 for exactly one cycle with io_read_data valid; per_sel=0; go to GAP.
REQ-022 GAP: lasts one cycle, ignores io_bus_enable, then goes to IDLE.
REQ-023 Latency: io_acknowledge SHALL be high 2 cycles after IDLE samples io_bus_enable when ready is already high (internal accesses likewise).
REQ-024 io_read_data SHALL be 0 in every cycle other than ACK; write transfers return 0.
REQ-025 Internal registers SHALL use byte offset io_address[3:0]; a write takes effect only when io_byte_enable[0]=1.
- 0x0 IRQ_PEND: read {12'b0, pend[3:0]}; write 1 to clear.
- 0x2 IRQ_MASK: read/write, bits[3:0].
- 0x4 STATUS: bit0 timeout, bit1 decode error; sticky; write 1 to clear.
- Any other offset reads 0; writes to it are ignored.
REQ-026 pend[i] SHALL set on a rising edge of per_irq[i], detected against a registered copy of the previous value.
REQ-027 When a set and a write-1-clear of pend[i] or a STATUS bit occur in the same cycle, the set SHALL win.
REQ-028 io_irq SHALL be registered: io_irq <= |(pend & IRQ_MASK), one cycle after the change.
REQ-029 io_byte_enable SHALL be passed through to per_be unchanged; the block does not merge bytes.

Reset
REQ-030 Asserting reset_reset SHALL, immediately and regardless of state (including mid-ACCESS), set:
- state = IDLE;
- per_sel = 0;
- io_acknowledge = 0;
- io_read_data = 0;
- io_irq = 0;
- pend, IRQ_MASK, STATUS, the timeout counter and the previous-per_irq copy all 0;
- per_addr, per_rw, per_be, per_wdata all 0.
REQ-031 No acknowledge SHALL be issued for a transfer interrupted by reset.

Verification
REQ-032 Read slot 2 with per_ready[2] high and per_rdata[47:32]=0x1234 -> per_sel=0100 for one cycle, io_read_data=0x1234, a single ack pulse 2 cycles after the request.
REQ-033 Write 0x00AB to 0x1010 with per_ready[1] held low for 4 cycles -> per_sel=0010 for 5 cycles, per_wdata=0x00AB, per_addr=0x010, ack on the next cycle.
REQ-034 TIMEOUT=8, read slot 0 with ready never high -> ack after 8 ACCESS cycles, data 0xDEAD, STATUS=0x0001; a read of 0xF004 returns 1; writing 1 to 0xF004 clears it.
REQ-035 Read of 0x5000 -> data 0xDEAD, STATUS.bit1=1. Write IRQ_MASK=0x3, pulse per_irq[1] -> pend=0x2 and io_irq=1 a cycle later; writing 0x2 to 0xF000 -> io_irq=0.
REQ-036 Rising edge on per_irq[0] in the same cycle as a write-1-clear of pend[0] -> pend[0] stays 1.
REQ-037 reset_reset asserted mid-ACCESS -> per_sel=0 and no ack immediately; the next request after reset completes normally.
